// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO for the EX stage
//
// Optional feature macro: MD_DIVZERO_EN adds the div_zero flag output.
//
// Ports:
//   Clk          in   1   clock, rising edge
//   Reset        in   1   asynchronous, active-low
//   E_md_signal  in   1   md instruction valid in EX
//   E_md_control in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   E_A          in   32  rs operand (forwarded)
//   E_B          in   32  rt operand (forwarded)
//   E_use_hilo   in   1   mfhi/mflo in EX
//   E_hold       in   1   EX held by another hazard; suppresses accept
//   busy         out  4   cycles remaining (0 = idle)
//   md_stall     out  1   stall request to IF/ID/EX
//   md_done      out  1   one-cycle pulse after HI/LO updated by mult/div
//   res_hi       out  32  HI register
//   res_lo       out  32  LO register
//   div_zero     out  1   (MD_DIVZERO_EN only) last completed div had a zero divisor
module md_unit_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        E_md_signal,
    input  logic [2:0]  E_md_control,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_use_hilo,
    input  logic        E_hold,
    output logic [3:0]  busy,
    output logic        md_stall,
    output logic        md_done,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
`ifdef MD_DIVZERO_EN
    ,
    output logic        div_zero
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [3:0] MUL_CNT = MUL_LAT[3:0];
    localparam logic [3:0] DIV_CNT = DIV_LAT[3:0];

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;

    logic        accept;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        b_is_zero;

    // busy==0 already implies md_stall==0, so the stall term is covered here.
    assign accept   = E_md_signal & (busy == 4'd0) & ~E_hold & (E_md_control <= 3'd5);
    assign md_stall = (busy != 4'd0) & (E_md_signal | E_use_hilo);

    // Sign/zero extension to 64 bits lets one unsigned multiply serve mult and multu.
    always_comb begin
        ext_a   = op_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        ext_b   = op_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product = ext_a * ext_b;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    always_comb begin
        b_is_zero = (op_b == 32'd0);
        a_mag     = (op_signed & op_a[31]) ? (32'd0 - op_a) : op_a;
        b_mag     = (op_signed & op_b[31]) ? (32'd0 - op_b) : op_b;
        if (b_is_zero) begin
            b_mag = 32'd1;
        end
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        quotient  = (op_signed & (op_a[31] ^ op_b[31])) ? (32'd0 - q_mag) : q_mag;
        remainder = (op_signed & op_a[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            busy      <= 4'd0;
            md_done   <= 1'b0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_signed <= 1'b0;
`ifdef MD_DIVZERO_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            md_done <= 1'b0;
            if (busy > 4'd1) begin
                busy <= busy - 4'd1;
            end else if (busy == 4'd1) begin
                busy    <= 4'd0;
                state   <= ST_IDLE;
                md_done <= 1'b1;
                if (state == ST_DIV) begin
                    if (!b_is_zero) begin
                        res_hi <= remainder;
                        res_lo <= quotient;
                    end
`ifdef MD_DIVZERO_EN
                    div_zero <= b_is_zero;
`endif
                end else begin
                    res_hi <= product[63:32];
                    res_lo <= product[31:0];
                end
            end else if (accept) begin
                case (E_md_control)
                    3'd0, 3'd1: begin
                        op_a      <= E_A;
                        op_b      <= E_B;
                        op_signed <= ~E_md_control[0];
                        busy      <= MUL_CNT;
                        state     <= ST_MUL;
`ifdef MD_DIVZERO_EN
                        div_zero  <= 1'b0;
`endif
                    end
                    3'd2, 3'd3: begin
                        op_a      <= E_A;
                        op_b      <= E_B;
                        op_signed <= ~E_md_control[0];
                        busy      <= DIV_CNT;
                        state     <= ST_DIV;
`ifdef MD_DIVZERO_EN
                        div_zero  <= 1'b0;
`endif
                    end
                    3'd4:    res_hi <= E_A;
                    3'd5:    res_lo <= E_A;
                    default: ;
                endcase
            end
        end
    end

endmodule
